// File: rtl/req_encoder4x2_pkg.sv
// Shared constants and helpers for the 4-to-2 request encoder.
// The optional drop counter is enabled with the macro REQ_ENC_DROP_CNT_EN.
package req_enc_pkg;

  localparam int NUM_REQ = 4;
  localparam int CODE_W  = 2;

  localparam logic [CODE_W-1:0] CODE_0 = 2'b00;
  localparam logic [CODE_W-1:0] CODE_1 = 2'b01;
  localparam logic [CODE_W-1:0] CODE_2 = 2'b10;
  localparam logic [CODE_W-1:0] CODE_3 = 2'b11;

  function automatic logic [2:0] count_ones(input logic [NUM_REQ-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/req_encoder4x2_if.sv
// Request/grant bundle between a request source (master) and the encoder (slave).
interface req_encoder4x2_if
  import req_enc_pkg::*;
#(
  parameter int CNT_W = 8
);
  logic               i0;
  logic               i1;
  logic               i2;
  logic               i3;
  logic               in_vld;
  logic               out_rdy;
  logic               s1;
  logic               s0;
  logic               out_vld;
  logic [NUM_REQ-1:0] pend;
  logic [CNT_W-1:0]   drop_cnt;

  modport master (
    output i0, i1, i2, i3, in_vld, out_rdy,
    input  s1, s0, out_vld, pend, drop_cnt
  );

  modport slave (
    input  i0, i1, i2, i3, in_vld, out_rdy,
    output s1, s0, out_vld, pend, drop_cnt
  );
endinterface

// File: rtl/req_encoder4x2_pri_enc4.sv
// Lowest-index-first priority encoder over a 4-bit vector.
module pri_enc4
  import req_enc_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  output logic [CODE_W-1:0]  code,
  output logic               any
);

  always_comb begin
    any  = |vec;
    code = CODE_0;
    if (vec[0])      code = CODE_0;
    else if (vec[1]) code = CODE_1;
    else if (vec[2]) code = CODE_2;
    else if (vec[3]) code = CODE_3;
  end

endmodule

// File: rtl/req_encoder4x2.sv
// Pending-request register with priority encode and ready/valid drain.
// Define REQ_ENC_DROP_CNT_EN to count requests merged into an already pending bit.
module req_encoder4x2
  import req_enc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  req_encoder4x2_if.slave  bus
);

  logic [NUM_REQ-1:0] pend_reg;
  logic [NUM_REQ-1:0] pend_next;
  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] cap_vec;
  logic [NUM_REQ-1:0] clr_vec;
  logic [CODE_W-1:0]  code;
  logic               any;

  assign req_vec = {bus.i3, bus.i2, bus.i1, bus.i0};
  assign cap_vec = bus.in_vld ? req_vec : '0;

  pri_enc4 u_pri_enc4 (
    .vec  (pend_reg),
    .code (code),
    .any  (any)
  );

  // One-hot clear of the granted bit; empty pend means no grant regardless of out_rdy.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_clr
      assign clr_vec[gi] = any && bus.out_rdy && (code == CODE_W'(gi));
    end
  endgenerate

  // Capture is OR-ed after the clear so a same-cycle re-request keeps the bit set.
  assign pend_next = (pend_reg & ~clr_vec) | cap_vec;

  always_ff @(posedge clk) begin
    if (rst) pend_reg <= '0;
    else     pend_reg <= pend_next;
  end

  assign bus.pend    = pend_reg;
  assign bus.out_vld = any;
  assign bus.s1      = code[1];
  assign bus.s0      = code[0];

`ifdef REQ_ENC_DROP_CNT_EN
  logic [NUM_REQ-1:0] merge_vec;
  logic [CNT_W-1:0]   drop_cnt_reg;
  logic [CNT_W+2:0]   drop_sum;

  assign merge_vec = cap_vec & pend_reg & ~clr_vec;
  assign drop_sum  = {3'b000, drop_cnt_reg} + (CNT_W+3)'(count_ones(merge_vec));

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (drop_sum > {3'b000, {CNT_W{1'b1}}}) begin
      drop_cnt_reg <= {CNT_W{1'b1}};
    end else begin
      drop_cnt_reg <= drop_sum[CNT_W-1:0];
    end
  end

  assign bus.drop_cnt = drop_cnt_reg;
`else
  assign bus.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_req_encoder4x2.sv
// Directed plus random stimulus for req_encoder4x2 against a pending-set reference model.
module tb_req_encoder4x2;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  req_encoder4x2_if #(.CNT_W(CNT_W)) bus ();

  req_encoder4x2 #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // Reference model: set of outstanding request indices plus merge counter.
  bit m_pend [4];
  int m_drop;

  function automatic int m_lowest();
    for (int i = 0; i < 4; i++) if (m_pend[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] m_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int g;
    g = m_lowest();
    chk({tag, ".out_vld"}, {7'd0, bus.out_vld}, {7'd0, (g >= 0)});
    chk({tag, ".code"},    {6'd0, bus.s1, bus.s0}, (g < 0) ? 8'd0 : 8'(g));
    chk({tag, ".pend"},    {4'd0, bus.pend}, {4'd0, m_vec()});
    chk({tag, ".drop"},    {6'd0, bus.drop_cnt}, 8'(m_drop));
  endtask

  // Drive one cycle, advance the model across the edge, then compare just after the edge.
  task automatic step(input string tag, input bit r, input bit vld, input logic [3:0] req, input bit rdy);
    int g;
    rst = r; bus.in_vld = vld; bus.out_rdy = rdy;
    bus.i0 = req[0]; bus.i1 = req[1]; bus.i2 = req[2]; bus.i3 = req[3];
    @(posedge clk);
    cyc_n++;
    if (r) begin
      for (int i = 0; i < 4; i++) m_pend[i] = 0;
      m_drop = 0;
    end else begin
      g = m_lowest();
      if (rdy && g >= 0) m_pend[g] = 0;
      for (int i = 0; i < 4; i++) begin
        if (vld && req[i]) begin
`ifdef REQ_ENC_DROP_CNT_EN
          if (m_pend[i] && m_drop < CNT_MAX) m_drop++;
`endif
          m_pend[i] = 1;
        end
      end
    end
    #1;
    $display("cyc=%0d %s rst=%0b vld=%0b req=%b rdy=%0b -> out_vld=%0b s=%0b%0b pend=%b drop=%0d",
             cyc_n, tag, r, vld, req, rdy, bus.out_vld, bus.s1, bus.s0, bus.pend, bus.drop_cnt);
    check_model(tag);
  endtask

  initial begin
    m_drop = 0;
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
    rst = 1'b1; bus.in_vld = 1'b0; bus.out_rdy = 1'b0;
    bus.i0 = 1'b0; bus.i1 = 1'b0; bus.i2 = 1'b0; bus.i3 = 1'b0;

    // Reset with capture of a single request, stalled, then drained
    step("rst0", 1, 1, 4'b1111, 1);
    step("rst1", 1, 0, 4'b0000, 0);
    chk("reset_state", {bus.out_vld, bus.s1, bus.s0, bus.pend, 1'b0}, 8'h00);
    step("cap2", 0, 1, 4'b0100, 0);
    chk("cap2_const", {bus.out_vld, bus.s1, bus.s0, bus.pend, 1'b0}, {1'b1, 2'b10, 4'b0100, 1'b0});
    step("hold_a", 0, 0, 4'b0000, 0);
    step("hold_b", 0, 0, 4'b1011, 0);
    step("drain2", 0, 0, 4'b0000, 1);
    chk("drain2_pend", {4'd0, bus.pend}, 8'h00);

    // Full burst drains in order 0,1,2,3
    step("burst", 0, 1, 4'b1111, 1);
    for (int k = 0; k < 4; k++) begin
      chk("burst_code", {6'd0, bus.s1, bus.s0}, 8'(k));
      step("drain", 0, 0, 4'b0000, 1);
    end
    chk("burst_empty", {7'd0, bus.out_vld}, 8'd0);

    // Same-cycle capture and clear keeps the bit
    step("cap0", 0, 1, 4'b0001, 0);
    step("recap0", 0, 1, 4'b0001, 1);
    chk("recap0_const", {bus.out_vld, bus.pend, 3'd0}, {1'b1, 4'b0001, 3'd0});
    step("clr0", 0, 0, 4'b0000, 1);

    // Lower-index capture preempts a stalled code
    step("cap3", 0, 1, 4'b1000, 0);
    step("cap1", 0, 1, 4'b0010, 0);
    chk("preempt_const", {bus.s1, bus.s0, bus.pend, 2'd0}, {2'b01, 4'b1010, 2'd0});
    step("drn_a", 0, 0, 4'b0000, 1);
    step("drn_b", 0, 0, 4'b0000, 1);

    // Merge counting saturates
    step("fill", 0, 1, 4'b1111, 0);
    step("merge1", 0, 1, 4'b1111, 0);
    step("merge2", 0, 1, 4'b1111, 0);
`ifdef REQ_ENC_DROP_CNT_EN
    chk("drop_sat", {6'd0, bus.drop_cnt}, 8'd3);
`else
    chk("drop_tied", {6'd0, bus.drop_cnt}, 8'd0);
`endif
    for (int k = 0; k < 4; k++) step("flush", 0, 0, 4'b0000, 1);

    // Reset overrides mid-drain capture and handshake
    step("cap6", 0, 1, 4'b0110, 0);
    step("drn6", 0, 0, 4'b0000, 1);
    step("rst_mid", 1, 1, 4'b1111, 1);
    chk("rst_mid_const", {bus.out_vld, bus.s1, bus.s0, bus.pend, bus.drop_cnt == '0}, 8'h01);
    step("resume", 0, 1, 4'b1000, 0);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      step("rnd", ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_encoder4x2.md
REQ_ENCODER4X2 -- requirements
Module: req_encoder4x2

Interface
REQ-001 Parameter CNT_W, default 8, width of the optional drop counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i0..i3  input  1 each  request lines; i0 highest priority.
REQ-005 in_vld  input  1  qualifies i0..i3; lines ignored when low.
REQ-006 out_rdy  input  1  consumer accepts current code this cycle.
REQ-007 s1, s0  output  1 each  encoded index of granted request (s1 = MSB).
REQ-008 out_vld  output  1  s1/s0 hold a valid pending index.
REQ-009 pend  output  4  pending-request vector, bit n = line n.
REQ-010 drop_cnt  output  CNT_W  merged-request count (REQ-025 only).

Function
REQ-011 Block SHALL hold a 4-bit pending register; one set bit per outstanding request.
REQ-012 Capture: when in_vld=1, each in[n]=1 SHALL set pend[n] at the next edge.
REQ-013 out_vld SHALL equal OR of pend; no combinational path from i0..i3 or in_vld to any output.
REQ-014 s1/s0 SHALL encode lowest set index of pend (0->00, 1->01, 2->10, 3->11); 00 when pend=0.
REQ-015 Handshake: out_vld=1 and out_rdy=1 at an edge SHALL clear the encoded pend bit; exactly one bit per cycle.
REQ-016 out_rdy while out_vld=0 SHALL have no effect.
REQ-017 s1/s0/out_vld SHALL remain stable while out_vld=1 and out_rdy=0, unless a new lower-index request is captured (priority preemption allowed, drop never).
REQ-018 Latency: request presented at edge k SHALL appear on out_vld/s1/s0 after edge k+1 (one cycle).
REQ-019 Simultaneous capture and clear of the same bit SHALL leave the bit set (new request wins).
REQ-020 Capture of a bit already set (not cleared that cycle) SHALL merge into one pending request.
REQ-021 Throughput: all four pending with out_rdy held high SHALL drain in four consecutive cycles, order 0,1,2,3.

Reset
REQ-022 rst=1 at an edge SHALL clear pend to 0000, out_vld to 0, s1/s0 to 00, drop_cnt to 0.
REQ-023 rst SHALL override capture and handshake in the same cycle; mid-drain requests are discarded.
REQ-024 Inputs during reset SHALL be ignored; capture resumes at the first edge with rst=0.

Configuration
REQ-025 Macro REQ_ENC_DROP_CNT_EN defined: drop_cnt SHALL increment by one per merged bit (REQ-020), up to 4 per cycle, saturating at 2^CNT_W-1.
REQ-026 Macro undefined: drop_cnt port SHALL still exist, tied to 0; no counter logic present.

Structure
REQ-027 Package req_enc_pkg SHALL hold NUM_REQ=4, CODE_W=2 and the 2-bit code constants CODE_0..CODE_3.
REQ-028 Combinational lowest-index priority encoder SHALL be sub-module pri_enc4 (4-bit vector in, 2-bit code plus any-valid out), instantiated once.

Verification
REQ-029 rst high 2 cycles, then in_vld=1, i=0100 for 1 cycle, out_rdy=0 -> next cycle out_vld=1, s1s0=10, pend=0100; held until out_rdy=1, then pend=0000.
REQ-030 i=1111 one cycle, out_rdy=1 steady -> codes 00,01,10,11 on 4 consecutive cycles, then out_vld=0.
REQ-031 pend=0001 with out_rdy=1 and in_vld=1, i=0001 same cycle -> pend stays 0001, out_vld stays 1.
REQ-032 pend=1000 stalled, capture i=0010 -> s1s0 changes 11->01 next cycle; pend=1010.
REQ-033 REQ_ENC_DROP_CNT_EN defined, CNT_W=2: pend=1111 stalled, re-present 1111 twice -> drop_cnt saturates at 3; undefined -> drop_cnt stays 0.
REQ-034 pend=0110 draining, rst=1 for one cycle with in_vld=1, i=1111 -> pend=0000, out_vld=0, drop_cnt=0 next cycle.
